// File: rtl/reg_file_scoreboard_if.sv
// Issue/read/write-back bundle between the decode stage and the register file scoreboard.
interface reg_file_scoreboard_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] ra1;
  logic [ADDR_W-1:0] ra2;
  logic              use1;
  logic              use2;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic              issue_valid;
  logic [ADDR_W-1:0] issue_wa;
  logic              issue_ready;
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_wa;
  logic [DATA_W-1:0] wb_data;
  logic              stall;
  logic [ADDR_W:0]   pending_cnt;

  modport master (
    output ra1, ra2, use1, use2, issue_valid, issue_wa, wb_valid, wb_wa, wb_data,
    input  rd1, rd2, issue_ready, stall, pending_cnt
  );

  modport slave (
    input  ra1, ra2, use1, use2, issue_valid, issue_wa, wb_valid, wb_wa, wb_data,
    output rd1, rd2, issue_ready, stall, pending_cnt
  );
endinterface

// File: rtl/reg_file_scoreboard.sv
// 32x32 GPR file with two bypassed async read ports, one write-back port and a
// per-register busy scoreboard that raises stall on RAW/WAW hazards.
module reg_file_scoreboard #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREG   = 32
) (
  input logic                  clk,
  input logic                  rst_n,
  reg_file_scoreboard_if.slave bus
);

  logic [DATA_W-1:0] gpr_r [NREG];
  logic [NREG-1:0]   busy_r;
  logic [ADDR_W:0]   pending_cnt_r;
  logic [NREG-1:0]   clear_s;
  logic [NREG-1:0]   set_s;
  logic [NREG-1:0]   eff_busy_s;
  logic [NREG-1:0]   busy_next_s;
  logic              stall_s;
  logic              accept_s;

  function automatic logic [ADDR_W:0] popcount(input logic [NREG-1:0] v);
    logic [ADDR_W:0] n;
    n = '0;
    for (int i = 0; i < NREG; i++) begin
      n = n + {{ADDR_W{1'b0}}, v[i]};
    end
    return n;
  endfunction

  function automatic logic [DATA_W-1:0] read_mux(
    input logic [ADDR_W-1:0] ra,
    input logic              wv,
    input logic [ADDR_W-1:0] wa,
    input logic [DATA_W-1:0] wd,
    input logic [DATA_W-1:0] stored
  );
    logic [DATA_W-1:0] r;
    if (ra == '0) begin
      r = '0;
    end else if (wv && (wa == ra)) begin
      r = wd;
    end else begin
      r = stored;
    end
    return r;
  endfunction

  // Hazard detection; a same-cycle write-back resolves the hazard on its register.
  always_comb begin
    clear_s = '0;
    set_s   = '0;
    for (int i = 1; i < NREG; i++) begin
      clear_s[i] = bus.wb_valid & (bus.wb_wa == ADDR_W'(i));
    end
    eff_busy_s = busy_r & ~clear_s;
    stall_s    = (bus.use1 & eff_busy_s[bus.ra1]) |
                 (bus.use2 & eff_busy_s[bus.ra2]) |
                 (bus.issue_valid & eff_busy_s[bus.issue_wa]);
    accept_s   = bus.issue_valid & ~stall_s & (bus.issue_wa != '0);
    for (int i = 1; i < NREG; i++) begin
      set_s[i] = accept_s & (bus.issue_wa == ADDR_W'(i));
    end
    busy_next_s = eff_busy_s | set_s;
  end

  assign bus.rd1         = read_mux(bus.ra1, bus.wb_valid, bus.wb_wa, bus.wb_data, gpr_r[bus.ra1]);
  assign bus.rd2         = read_mux(bus.ra2, bus.wb_valid, bus.wb_wa, bus.wb_data, gpr_r[bus.ra2]);
  assign bus.stall       = stall_s;
  assign bus.issue_ready = ~stall_s;
  assign bus.pending_cnt = pending_cnt_r;

  // Register file, scoreboard and pending count; r0 is never written or marked busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        gpr_r[i] <= '0;
      end
      busy_r        <= '0;
      pending_cnt_r <= '0;
    end else begin
      if (bus.wb_valid && (bus.wb_wa != '0)) begin
        gpr_r[bus.wb_wa] <= bus.wb_data;
      end
      busy_r        <= busy_next_s;
      pending_cnt_r <= popcount(busy_next_s);
    end
  end

endmodule
